// File: rtl/robot_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : robot_motion_ctrl_if
//  Purpose  : Command/sensor inputs and status outputs of robot_motion_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface robot_motion_ctrl_if;
    logic       move_fwd;
    logic       move_bwd;
    logic       turn_left;
    logic       turn_right;
    logic       obstacle;
    logic       error;
    logic       recover;
    logic [3:0] state;
    logic       moving;
    logic       fault;
    logic [3:0] retry_cnt;

    // master drives commands and sensors; slave is the controller itself
    modport master (
        output move_fwd, move_bwd, turn_left, turn_right, obstacle, error, recover,
        input  state, moving, fault, retry_cnt
    );

    modport slave (
        input  move_fwd, move_bwd, turn_left, turn_right, obstacle, error, recover,
        output state, moving, fault, retry_cnt
    );
endinterface
`default_nettype wire

// File: rtl/robot_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : robot_motion_ctrl
//  Purpose  : Motion state machine with obstacle debounce, direction dwell,
//             timed recovery with retry limit, and optional command watchdog
//             (enabled by defining ROBOT_FSM_WDOG_EN).
//  Revision : 1.0  initial release
// ============================================================================
module robot_motion_ctrl #(
    parameter int unsigned DWELL_CYCLES   = 4,
    parameter int unsigned DEB_CYCLES     = 3,
    parameter int unsigned RECOVER_CYCLES = 8,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned WDOG_CYCLES    = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    robot_motion_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FORWARD  = 4'd1,
        ST_BACKWARD = 4'd2,
        ST_LEFT     = 4'd3,
        ST_RIGHT    = 4'd4,
        ST_STOP     = 4'd5,
        ST_ERROR    = 4'd6,
        ST_RECOVER  = 4'd7,
        ST_FAULT    = 4'd8
    } state_t;

    localparam logic [7:0] c_dwell_load = 8'(DWELL_CYCLES - 1);
    localparam logic [7:0] c_deb_sat    = 8'(DEB_CYCLES);
    localparam logic [7:0] c_deb_hit    = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] c_rec_load   = 8'(RECOVER_CYCLES - 1);
    localparam logic [3:0] c_max_retry  = 4'(MAX_RETRY);

    if ((DWELL_CYCLES < 1) || (DWELL_CYCLES > 255) || (DEB_CYCLES < 1) ||
        (DEB_CYCLES > 255) || (RECOVER_CYCLES < 1) || (RECOVER_CYCLES > 255) ||
        (MAX_RETRY < 1) || (MAX_RETRY > 15) || (WDOG_CYCLES < 1) ||
        (WDOG_CYCLES > 65535)) begin : g_param_check
        $error("robot_motion_ctrl: parameter out of legal range");
    end

    state_t     r_state;
    state_t     w_next;
    state_t     w_req_dir;
    logic       w_req_valid;
    logic [7:0] r_deb_cnt;
    logic [7:0] r_dwell;
    logic [7:0] r_rec_tmr;
    logic [3:0] r_retry;
    logic [3:0] w_retry_next;
    logic       w_obs_hit;
    logic       w_motion;
    logic       w_next_motion;
    logic       w_wdog_expire;

    assign w_obs_hit     = bus.obstacle && (r_deb_cnt >= c_deb_hit);
    assign w_motion      = (r_state == ST_FORWARD) || (r_state == ST_BACKWARD) ||
                           (r_state == ST_LEFT)    || (r_state == ST_RIGHT);
    assign w_next_motion = (w_next == ST_FORWARD) || (w_next == ST_BACKWARD) ||
                           (w_next == ST_LEFT)    || (w_next == ST_RIGHT);

    always_comb begin
        w_req_dir   = ST_IDLE;
        w_req_valid = 1'b1;
        if (bus.move_fwd)        w_req_dir = ST_FORWARD;
        else if (bus.move_bwd)   w_req_dir = ST_BACKWARD;
        else if (bus.turn_left)  w_req_dir = ST_LEFT;
        else if (bus.turn_right) w_req_dir = ST_RIGHT;
        else                     w_req_valid = 1'b0;
    end

`ifdef ROBOT_FSM_WDOG_EN
    localparam logic [15:0] c_wdog_last = 16'(WDOG_CYCLES - 1);
    logic [15:0] r_wdog_cnt;

    // expiry fires on the WDOG_CYCLES-th consecutive command-free motion cycle
    assign w_wdog_expire = w_motion && !w_req_valid && (r_wdog_cnt == c_wdog_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog_cnt <= 16'd0;
        end else if (!w_motion || w_req_valid || (w_next != r_state)) begin
            r_wdog_cnt <= 16'd0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
        end
    end
`else
    assign w_wdog_expire = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        w_retry_next = r_retry;
        case (r_state)
            ST_IDLE, ST_FORWARD, ST_BACKWARD, ST_LEFT, ST_RIGHT: begin
                if (bus.error)          w_next = ST_ERROR;
                else if (w_obs_hit)     w_next = ST_STOP;
                else if (w_wdog_expire) w_next = ST_IDLE;
                else if (w_req_valid && ((r_state == ST_IDLE) || (r_dwell == 8'd0)))
                    w_next = w_req_dir;
            end
            ST_STOP: begin
                if (bus.error)                          w_next = ST_ERROR;
                else if (bus.recover)                   w_next = ST_RECOVER;
                else if (!bus.obstacle && w_req_valid)  w_next = w_req_dir;
            end
            ST_ERROR: begin
                if (bus.recover) w_next = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (bus.error) begin
                    w_retry_next = r_retry + 4'd1;
                    w_next       = (w_retry_next == c_max_retry) ? ST_FAULT : ST_ERROR;
                end else if (r_rec_tmr == 8'd0) begin
                    if (!bus.obstacle) begin
                        w_next       = ST_IDLE;
                        w_retry_next = 4'd0;
                    end else begin
                        w_next = ST_STOP;
                    end
                end
            end
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_retry <= 4'd0;
        end else begin
            r_state <= w_next;
            r_retry <= w_retry_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_cnt <= 8'd0;
            r_dwell   <= 8'd0;
            r_rec_tmr <= 8'd0;
        end else begin
            if (!bus.obstacle)
                r_deb_cnt <= 8'd0;
            else if (r_deb_cnt < c_deb_sat)
                r_deb_cnt <= r_deb_cnt + 8'd1;

            if ((w_next != r_state) && w_next_motion)
                r_dwell <= c_dwell_load;
            else if (r_dwell != 8'd0)
                r_dwell <= r_dwell - 8'd1;

            if ((w_next == ST_RECOVER) && (r_state != ST_RECOVER))
                r_rec_tmr <= c_rec_load;
            else if ((r_state == ST_RECOVER) && (r_rec_tmr != 8'd0))
                r_rec_tmr <= r_rec_tmr - 8'd1;
        end
    end

    assign bus.state     = r_state;
    assign bus.moving    = w_motion;
    assign bus.fault     = (r_state == ST_FAULT);
    assign bus.retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: doc/robot_motion_ctrl.md
ROBOT_MOTION_CTRL -- requirements
Module: robot_motion_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 4: minimum cycles in a motion state before a direction change; legal range 1..255.
REQ-002 Parameter DEB_CYCLES, default 3: consecutive sampled-high cycles of obstacle needed to act on it; legal range 1..255.
REQ-003 Parameter RECOVER_CYCLES, default 8: duration of RECOVER before its exit is evaluated; legal range 1..255.
REQ-004 Parameter MAX_RETRY, default 3: failed recoveries that force FAULT; legal range 1..15.
REQ-005 Parameter WDOG_CYCLES, default 16: command-idle timeout in motion states, used only under REQ-030; legal range 1..65535.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 move_fwd, move_bwd, turn_left, turn_right  input  1 each  motion commands, level-sensitive.
REQ-009 obstacle, error, recover  input  1 each  raw obstacle, error and recovery-request levels.
REQ-010 state  output  4  encoding IDLE=0, FORWARD=1, BACKWARD=2, LEFT=3, RIGHT=4, STOP=5, ERROR=6, RECOVER=7, FAULT=8.
REQ-011 moving  output  1  high when state is FORWARD, BACKWARD, LEFT or RIGHT.
REQ-012 fault  output  1  high when state is FAULT.
REQ-013 retry_cnt  output  4  count of failed recoveries since the last successful one.

Function
REQ-014 Command priority SHALL be move_fwd > move_bwd > turn_left > turn_right; the highest-priority asserted command is the requested direction.
REQ-015 Debounce counter SHALL count consecutive cycles with obstacle high, saturate at DEB_CYCLES, and clear on any cycle with obstacle low; obs_hit = obstacle AND (count >= DEB_CYCLES-1).
REQ-016 From IDLE and all motion states, the priority SHALL be: error -> ERROR; else obs_hit -> STOP; else requested direction, subject to REQ-017; else hold (IDLE stays IDLE, motion state stays put).
REQ-017 On entry to any motion state the dwell counter SHALL load DWELL_CYCLES-1 and decrement each cycle to 0; a change to a different direction is allowed only when the counter is 0; error and obs_hit override dwell immediately.
REQ-018 STOP transitions: error -> ERROR; else recover -> RECOVER; else obstacle low with a requested direction -> that direction; else stay in STOP.
REQ-019 ERROR SHALL move to RECOVER when recover is high, otherwise stay in ERROR.
REQ-020 On entry to RECOVER the timer SHALL load RECOVER_CYCLES-1; error high on any RECOVER cycle SHALL end recovery at once as a failure.
REQ-021 When the timer reaches 0 with error low: obstacle low -> IDLE and retry_cnt cleared; obstacle high -> STOP with retry_cnt unchanged.
REQ-022 A recovery failure SHALL increment retry_cnt and go to ERROR, or go to FAULT if the incremented value equals MAX_RETRY.
REQ-023 FAULT SHALL be left only by reset; all inputs are ignored while in FAULT.
REQ-024 An unused encoding (9..15) SHALL go to IDLE on the next edge.
REQ-025 Outputs SHALL be registered or decoded from registered state only; there is no combinational path from inputs to outputs.

Reset
REQ-026 While rst is high: state=IDLE, moving=0, fault=0, retry_cnt=0, and the debounce, dwell, recovery and watchdog counters are 0.
REQ-027 Reset SHALL take effect asynchronously, including in the middle of dwell, recovery or FAULT.
REQ-028 On release the block SHALL evaluate normally from the first rising edge.

Configuration
REQ-029 The macro ROBOT_FSM_WDOG_EN SHALL select the command watchdog.
REQ-030 With ROBOT_FSM_WDOG_EN defined: in a motion state, a counter counts cycles with all four commands low and clears when any command is high or the state changes; when it reaches WDOG_CYCLES the state goes to IDLE, unless error or obs_hit takes priority.
REQ-031 With ROBOT_FSM_WDOG_EN undefined: no watchdog logic, and a motion state holds indefinitely without commands.

Verification
REQ-032 Scenario: move_fwd pulsed 1 cycle after reset, then move_bwd held -> FORWARD for exactly 4 cycles, then BACKWARD.
REQ-033 Scenario: obstacle high for 2 cycles then low, then high for 3 cycles, while in FORWARD -> no STOP after the first burst; STOP on the 3rd high edge of the second burst.
REQ-034 Scenario: in ERROR assert recover, with error low and obstacle low -> RECOVER for 8 cycles, then IDLE with retry_cnt=0.
REQ-035 Scenario: 3 consecutive recoveries, each with error reasserted mid-RECOVER -> retry_cnt 1, then 2, then state FAULT with fault=1; FAULT persists until rst pulses.
REQ-036 Scenario: WDOG_EN build, in LEFT with all commands low for 16 cycles -> IDLE; non-WDOG build, same stimulus -> stays LEFT.
REQ-037 Scenario: rst asserted mid-RECOVER with retry_cnt=2 -> state=IDLE and retry_cnt=0 immediately, without waiting for a clock edge.
